// File: rtl/ce_array_scheduler.sv
// ce_array_scheduler: dispatches tile commands round-robin to NUM_CE compute engines,
// buffers each engine's results in its own FIFO and merges them back in dispatch order.
// Optional feature macro: CE_SCHED_PERF_EN adds saturating busy/stall/tile counters.
module ce_array_scheduler #(
  parameter int unsigned NUM_CE         = 4,
  parameter int unsigned CMD_WIDTH      = 128,
  parameter int unsigned RES_WIDTH      = 16,
  parameter int unsigned RES_FIFO_DEPTH = 64,
  parameter int unsigned ORD_DEPTH      = 8,
  parameter int unsigned CNT_WIDTH      = 15
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_tile_valid,
  input  logic [CMD_WIDTH-1:0]          i_tile_cmd,
  input  logic [CNT_WIDTH-1:0]          i_tile_res_cnt,
  output logic                          o_tile_ready,
  output logic                          o_tile_done,
  output logic [NUM_CE-1:0]             o_ce_tile_en,
  output logic [CMD_WIDTH-1:0]          o_ce_tile_cmd,
  input  logic [NUM_CE-1:0]             i_ce_tile_done,
  input  logic [NUM_CE*RES_WIDTH-1:0]   i_ce_res_data,
  input  logic [NUM_CE-1:0]             i_ce_res_valid,
  output logic [NUM_CE-1:0]             o_ce_res_afull,
  output logic [RES_WIDTH-1:0]          o_result_data,
  output logic                          o_result_valid,
  input  logic                          i_result_full,
  output logic [NUM_CE-1:0]             o_ce_busy,
  output logic                          o_busy,
`ifdef CE_SCHED_PERF_EN
  output logic [31:0]                   o_perf_busy_cycles,
  output logic [31:0]                   o_perf_stall_cycles,
  output logic [15:0]                   o_perf_tiles,
`endif
  output logic [2:0]                    o_err
);

  localparam int unsigned IdW = (NUM_CE > 1) ? $clog2(NUM_CE) : 1;
  localparam int unsigned RAw = $clog2(RES_FIFO_DEPTH);
  localparam int unsigned OAw = $clog2(ORD_DEPTH);
  localparam int unsigned PW  = $clog2(ORD_DEPTH + 2) + 1;
  localparam logic [RAw:0] AfullLvl = (RAw+1)'(RES_FIFO_DEPTH - 4);

  typedef enum logic [1:0] {StIdle, StStream, StDone} merge_state_e;

  // Dispatch state
  logic [NUM_CE-1:0]    busy_q, busy_d;
  logic [IdW-1:0]       last_grant_q, last_grant_d;
  logic [NUM_CE-1:0]    tile_en_q, tile_en_d;
  logic [CMD_WIDTH-1:0] tile_cmd_q, tile_cmd_d;
  logic                 tile_ready_q, tile_ready_d;
  logic                 grant_found, hs;
  logic [IdW-1:0]       grant_id;

  // Dispatch-order FIFO
  logic [IdW-1:0]       ord_id_q  [ORD_DEPTH];
  logic [CNT_WIDTH-1:0] ord_cnt_q [ORD_DEPTH];
  logic [OAw:0]         ord_wr_q, ord_wr_d, ord_rd_q, ord_rd_d;
  logic                 ord_empty, ord_pop;

  // Per-engine result FIFOs
  logic [RES_WIDTH-1:0] res_mem_q [NUM_CE][RES_FIFO_DEPTH];
  logic [RAw:0]         res_wr_q [NUM_CE];
  logic [RAw:0]         res_wr_d [NUM_CE];
  logic [RAw:0]         res_rd_q [NUM_CE];
  logic [RAw:0]         res_rd_d [NUM_CE];
  logic [NUM_CE-1:0]    res_empty, res_full, res_push, res_pop;
  logic [NUM_CE-1:0]    afull_q, afull_d;
  // Tiles dispatched to each engine that the merger has not yet retired
  logic [PW-1:0]        pend_q [NUM_CE];
  logic [PW-1:0]        pend_d [NUM_CE];
  logic [2:0]           err_q, err_d;

  // Merger
  merge_state_e         state_q, state_d;
  logic [IdW-1:0]       head_id_q, head_id_d;
  logic [CNT_WIDTH-1:0] remain_q, remain_d;
  logic [RES_WIDTH-1:0] res_data_q, res_data_d;
  logic                 res_valid_q, res_valid_d;
  logic                 tile_done_q, tile_done_d;

  // Round-robin search for the first idle engine after the last grant
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int unsigned i = 1; i <= NUM_CE; i++) begin
      idx = (32'(last_grant_q) + i) % NUM_CE;
      if (!grant_found && !busy_q[idx[IdW-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = idx[IdW-1:0];
      end
    end
  end

  assign hs = i_tile_valid & tile_ready_q & grant_found;

  // Order FIFO pointers and dispatch outputs
  always_comb begin
    ord_empty    = (ord_wr_q == ord_rd_q);
    ord_pop      = (state_q == StIdle) && !ord_empty;
    ord_wr_d     = ord_wr_q + (OAw+1)'(hs);
    ord_rd_d     = ord_rd_q + (OAw+1)'(ord_pop);
    tile_en_d    = hs ? (NUM_CE'(1) << grant_id) : '0;
    tile_cmd_d   = hs ? i_tile_cmd : tile_cmd_q;
    last_grant_d = hs ? grant_id : last_grant_q;
    // Ready is registered from next state so throughput stays one tile per cycle
    tile_ready_d = (|(~busy_d)) && (ord_wr_d != {~ord_rd_d[OAw], ord_rd_d[OAw-1:0]});
  end

  // Engine busy tracking, result FIFO push/pop and sticky error flags
  always_comb begin
    logic res_ok;
    res_ok = 1'b0;
    busy_d = busy_q;
    err_d  = err_q;
    for (int k = 0; k < NUM_CE; k++) begin
      if (i_ce_tile_done[k]) begin
        if (busy_q[k]) busy_d[k] = 1'b0;
        else           err_d[2]  = 1'b1;
      end
      res_empty[k] = (res_wr_q[k] == res_rd_q[k]);
      res_full[k]  = (res_wr_q[k] == {~res_rd_q[k][RAw], res_rd_q[k][RAw-1:0]});
      res_pop[k]   = (state_q == StStream) && (head_id_q == IdW'(k)) && !res_empty[k] &&
                     !i_result_full;
      res_ok       = busy_q[k] || (pend_q[k] != '0);
      // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
      res_push[k]  = i_ce_res_valid[k] && res_ok && (!res_full[k] || res_pop[k]);
      if (i_ce_res_valid[k] && !res_ok) err_d[1] = 1'b1;
      if (i_ce_res_valid[k] && res_ok && res_full[k] && !res_pop[k]) err_d[0] = 1'b1;
      res_wr_d[k]  = res_wr_q[k] + (RAw+1)'(res_push[k]);
      res_rd_d[k]  = res_rd_q[k] + (RAw+1)'(res_pop[k]);
      afull_d[k]   = (res_wr_d[k] - res_rd_d[k]) >= AfullLvl;
      pend_d[k]    = pend_q[k];
      if (hs && grant_id == IdW'(k)) pend_d[k] = pend_d[k] + PW'(1);
      if (state_q == StDone && head_id_q == IdW'(k)) pend_d[k] = pend_d[k] - PW'(1);
    end
    if (hs) busy_d[grant_id] = 1'b1;
  end

  // Merger next state: pop order entry, stream its word count, then pulse done
  always_comb begin
    state_d     = state_q;
    head_id_d   = head_id_q;
    remain_d    = remain_q;
    res_data_d  = res_data_q;
    res_valid_d = 1'b0;
    tile_done_d = (state_q == StDone);
    unique case (state_q)
      StIdle: begin
        if (!ord_empty) begin
          head_id_d = ord_id_q[ord_rd_q[OAw-1:0]];
          remain_d  = ord_cnt_q[ord_rd_q[OAw-1:0]];
          state_d   = (ord_cnt_q[ord_rd_q[OAw-1:0]] == '0) ? StDone : StStream;
        end
      end
      StStream: begin
        if (res_pop[head_id_q]) begin
          res_valid_d = 1'b1;
          res_data_d  = res_mem_q[head_id_q][res_rd_q[head_id_q][RAw-1:0]];
          remain_d    = remain_q - CNT_WIDTH'(1);
          if (remain_q == CNT_WIDTH'(1)) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control state and registered outputs; reset flushes every in-flight tile
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      busy_q       <= '0;
      last_grant_q <= IdW'(NUM_CE - 1);
      tile_en_q    <= '0;
      tile_cmd_q   <= '0;
      tile_ready_q <= 1'b0;
      ord_wr_q     <= '0;
      ord_rd_q     <= '0;
      afull_q      <= '0;
      err_q        <= '0;
      state_q      <= StIdle;
      head_id_q    <= '0;
      remain_q     <= '0;
      res_data_q   <= '0;
      res_valid_q  <= 1'b0;
      tile_done_q  <= 1'b0;
      for (int k = 0; k < NUM_CE; k++) begin
        res_wr_q[k] <= '0;
        res_rd_q[k] <= '0;
        pend_q[k]   <= '0;
      end
    end else begin
      busy_q       <= busy_d;
      last_grant_q <= last_grant_d;
      tile_en_q    <= tile_en_d;
      tile_cmd_q   <= tile_cmd_d;
      tile_ready_q <= tile_ready_d;
      ord_wr_q     <= ord_wr_d;
      ord_rd_q     <= ord_rd_d;
      afull_q      <= afull_d;
      err_q        <= err_d;
      state_q      <= state_d;
      head_id_q    <= head_id_d;
      remain_q     <= remain_d;
      res_data_q   <= res_data_d;
      res_valid_q  <= res_valid_d;
      tile_done_q  <= tile_done_d;
      for (int k = 0; k < NUM_CE; k++) begin
        res_wr_q[k] <= res_wr_d[k];
        res_rd_q[k] <= res_rd_d[k];
        pend_q[k]   <= pend_d[k];
      end
    end
  end

  // FIFO storage; contents need no reset since pointers define validity
  always_ff @(posedge i_clk) begin
    if (hs) begin
      ord_id_q[ord_wr_q[OAw-1:0]]  <= grant_id;
      ord_cnt_q[ord_wr_q[OAw-1:0]] <= i_tile_res_cnt;
    end
    for (int k = 0; k < NUM_CE; k++) begin
      if (res_push[k]) res_mem_q[k][res_wr_q[k][RAw-1:0]] <= i_ce_res_data[k*RES_WIDTH +: RES_WIDTH];
    end
  end

`ifdef CE_SCHED_PERF_EN
  logic [31:0] perf_busy_q, perf_busy_d, perf_stall_q, perf_stall_d;
  logic [15:0] perf_tiles_q, perf_tiles_d;

  // Saturating performance counters
  always_comb begin
    perf_busy_d  = perf_busy_q;
    perf_stall_d = perf_stall_q;
    perf_tiles_d = perf_tiles_q;
    if ((|busy_q) && (perf_busy_q != '1)) perf_busy_d = perf_busy_q + 32'd1;
    if ((state_q == StStream) && i_result_full && (perf_stall_q != '1)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
    if ((state_q == StDone) && (perf_tiles_q != '1)) perf_tiles_d = perf_tiles_q + 16'd1;
  end

  // Counter registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
      perf_tiles_q <= '0;
    end else begin
      perf_busy_q  <= perf_busy_d;
      perf_stall_q <= perf_stall_d;
      perf_tiles_q <= perf_tiles_d;
    end
  end

  assign o_perf_busy_cycles  = perf_busy_q;
  assign o_perf_stall_cycles = perf_stall_q;
  assign o_perf_tiles        = perf_tiles_q;
`endif

  assign o_tile_ready   = tile_ready_q;
  assign o_tile_done    = tile_done_q;
  assign o_ce_tile_en   = tile_en_q;
  assign o_ce_tile_cmd  = tile_cmd_q;
  assign o_ce_res_afull = afull_q;
  assign o_result_data  = res_data_q;
  assign o_result_valid = res_valid_q;
  assign o_ce_busy      = busy_q;
  assign o_busy         = (|busy_q) | ~ord_empty | (state_q != StIdle);
  assign o_err          = err_q;

endmodule
